// File: rtl/wb_pkg.sv
// Shared types for the register-file write-port arbiter.
// Entry, FSM state and grant encodings plus default widths.
package wb_pkg;

  localparam int WB_DATA_W       = 32;
  localparam int WB_REG_W        = 5;
  localparam int WB_FIFO_DEPTH   = 2;
  localparam int WB_STARVE_LIMIT = 4;

  typedef struct packed {
    logic [WB_REG_W-1:0]  rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    WB_NORMAL,
    WB_DRAIN
  } wb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_FIFO,
    GNT_BYPASS
  } wb_grant_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between WB stage, LLU, register file and hazard unit.
// The arbiter takes the slave side.
interface wb_port_arbiter_if
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_W,
  parameter int REG_ADDR_W = WB_REG_W
);

  logic                     wb_valid_w;
  logic                     reg_write_w;
  logic [REG_ADDR_W-1:0]    rd_w;
  logic [DATA_WIDTH-1:0]    result_w;
  logic                     wb_stall;
  logic                     llu_issue;
  logic [REG_ADDR_W-1:0]    llu_issue_rd;
  logic                     llu_valid;
  logic [REG_ADDR_W-1:0]    llu_rd;
  logic [DATA_WIDTH-1:0]    llu_data;
  logic                     llu_ready;
  logic                     rf_we3;
  logic [REG_ADDR_W-1:0]    rf_a3;
  logic [DATA_WIDTH-1:0]    rf_wd3;
  logic [2**REG_ADDR_W-1:0] pending;

  modport slave (
    input  wb_valid_w, reg_write_w, rd_w, result_w,
    input  llu_issue, llu_issue_rd,
    input  llu_valid, llu_rd, llu_data,
    output wb_stall, llu_ready,
    output rf_we3, rf_a3, rf_wd3, pending
  );

  modport master (
    output wb_valid_w, reg_write_w, rd_w, result_w,
    output llu_issue, llu_issue_rd,
    output llu_valid, llu_rd, llu_data,
    input  wb_stall, llu_ready,
    input  rf_we3, rf_a3, rf_wd3, pending
  );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding LLU results that lost arbitration.
// Push and pop may happen in the same cycle.
module wb_fifo
  import wb_pkg::*;
#(
  parameter type T     = wb_entry_t,
  parameter int  DEPTH = WB_FIFO_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;

  // Extra pointer bit distinguishes full from empty.
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wp[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline WB and the LLU,
// with a result buffer, anti-starvation drain and pending scoreboard.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH   = WB_DATA_W,
  parameter int REG_ADDR_W   = WB_REG_W,
  parameter int FIFO_DEPTH   = WB_FIFO_DEPTH,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);

  localparam int NREG = 2**REG_ADDR_W;
  localparam int CW   = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  wb_state_t             state;
  wb_state_t             state_nxt;
  wb_grant_t             gnt;
  logic [CW-1:0]         starve;
  logic [CW-1:0]         starve_nxt;
  logic [NREG-1:0]       pend;
  logic [NREG-1:0]       pend_nxt;
  logic [REG_ADDR_W-1:0] a3_q;
  logic [DATA_WIDTH-1:0] wd3_q;
  entry_t                head;
  entry_t                llu_ent;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  pipe_req;
  logic                  llu_live;
  logic                  xfer;

  assign pipe_req = bus.wb_valid_w & bus.reg_write_w &
                    (bus.rd_w != '0);
  assign llu_live = bus.llu_valid & (bus.llu_rd != '0);
  assign llu_ent  = {bus.llu_rd, bus.llu_data};

  assign bus.llu_ready = !full & !rst;
  assign bus.wb_stall  = (state == WB_DRAIN) & !rst;
  assign xfer          = bus.llu_valid & bus.llu_ready;

  // Results with rd=0 are accepted but dropped.
  assign push = xfer & llu_live & (gnt != GNT_BYPASS);
  assign pop  = (gnt == GNT_FIFO);

  wb_fifo #(
    .T     (entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (llu_ent),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Bypass only when nothing is buffered, keeping LLU order.
  always_comb begin
    gnt = GNT_NONE;
    if (rst) begin
      gnt = GNT_NONE;
    end else if (state == WB_DRAIN) begin
      if (!empty) gnt = GNT_FIFO;
    end else if (pipe_req) begin
      gnt = GNT_PIPE;
    end else if (!empty) begin
      gnt = GNT_FIFO;
    end else if (llu_live) begin
      gnt = GNT_BYPASS;
    end
  end

  assign bus.rf_we3 = (gnt != GNT_NONE);

  always_comb begin
    bus.rf_a3  = a3_q;
    bus.rf_wd3 = wd3_q;
    unique case (gnt)
      GNT_PIPE: begin
        bus.rf_a3  = bus.rd_w;
        bus.rf_wd3 = bus.result_w;
      end
      GNT_FIFO: begin
        bus.rf_a3  = head.rd;
        bus.rf_wd3 = head.data;
      end
      GNT_BYPASS: begin
        bus.rf_a3  = bus.llu_rd;
        bus.rf_wd3 = bus.llu_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt  = WB_NORMAL;
    starve_nxt = starve;
    if (state == WB_DRAIN) begin
      starve_nxt = '0;
    end else begin
      if (gnt == GNT_FIFO) begin
        starve_nxt = '0;
      end else if (gnt == GNT_PIPE && !empty) begin
        starve_nxt = starve + 1'b1;
      end
      if (starve_nxt >= CW'(STARVE_LIMIT)) begin
        state_nxt = WB_DRAIN;
      end
    end
  end

  // Set after clear so a same-cycle reissue wins.
  always_comb begin
    pend_nxt = pend;
    if (gnt == GNT_FIFO)   pend_nxt[head.rd]    = 1'b0;
    if (gnt == GNT_BYPASS) pend_nxt[bus.llu_rd] = 1'b0;
    if (bus.llu_issue && bus.llu_issue_rd != '0) begin
      pend_nxt[bus.llu_issue_rd] = 1'b1;
    end
  end

  assign bus.pending = pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= WB_NORMAL;
      starve <= '0;
      pend   <= '0;
      a3_q   <= '0;
      wd3_q  <= '0;
    end else begin
      state  <= state_nxt;
      starve <= starve_nxt;
      pend   <= pend_nxt;
      if (bus.rf_we3) begin
        a3_q  <= bus.rf_a3;
        wd3_q <= bus.rf_wd3;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios with literal
// expectations, then random traffic against a queue-based model.
module tb_wb_port_arbiter;
  import wb_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  localparam int NR    = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(
    .DATA_WIDTH (DW),
    .REG_ADDR_W (AW)
  ) bus ();

  wb_port_arbiter #(
    .DATA_WIDTH   (DW),
    .REG_ADDR_W   (AW),
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          rd;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  int          inflight[$];
  int          starve = 0;
  bit          drain = 0;
  bit [NR-1:0] pend = '0;
  bit          last_acc = 0;
  bit          hz_en = 1;
  int          total = 0;
  int          bad = 0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic setp(bit v, int rd, logic [31:0] d);
    bus.wb_valid_w  = v;
    bus.reg_write_w = v;
    bus.rd_w        = AW'(rd);
    bus.result_w    = d;
  endtask

  task automatic setl(bit v, int rd, logic [31:0] d);
    bus.llu_valid = v;
    bus.llu_rd    = AW'(rd);
    bus.llu_data  = d;
  endtask

  task automatic seti(bit v, int rd);
    bus.llu_issue    = v;
    bus.llu_issue_rd = AW'(rd);
  endtask

  task automatic idle();
    setp(0, 0, 0);
    setl(0, 0, 0);
    seti(0, 0);
  endtask

  // Checks one cycle against the model, then advances the model.
  task automatic cycle();
    bit          preq;
    bit          acc;
    bit          e_we;
    bit          e_rdy;
    bit          e_stall;
    int          e_a3;
    logic [31:0] e_wd3;
    int          src;
    ent_t        e;
    #1;
    preq = bus.wb_valid_w && bus.reg_write_w &&
           bus.rd_w != 0;
    src = 0;
    e_a3 = 0;
    e_wd3 = 0;
    e_stall = !rst && drain;
    e_rdy = !rst && mq.size() < DEPTH;
    if (!rst) begin
      if (drain) begin
        if (mq.size() > 0) src = 2;
      end else if (preq) src = 1;
      else if (mq.size() > 0) src = 2;
      else if (bus.llu_valid && bus.llu_rd != 0) src = 3;
    end
    if (src == 1) begin
      e_a3 = int'(bus.rd_w);
      e_wd3 = bus.result_w;
    end else if (src == 2) begin
      e_a3 = mq[0].rd;
      e_wd3 = mq[0].d;
    end else if (src == 3) begin
      e_a3 = int'(bus.llu_rd);
      e_wd3 = bus.llu_data;
    end
    e_we = (src != 0);
    chk("we", 64'(bus.rf_we3), 64'(e_we));
    chk("stall", 64'(bus.wb_stall), 64'(e_stall));
    chk("ready", 64'(bus.llu_ready), 64'(e_rdy));
    chk("pending", 64'(bus.pending), 64'(pend));
    if (e_we) begin
      chk("a3", 64'(bus.rf_a3), 64'(e_a3));
      chk("wd3", 64'(bus.rf_wd3), 64'(e_wd3));
    end
    if (!rst && hz_en) begin
      if (bus.llu_issue && bus.llu_issue_rd != 0)
        chk("hz_issue",
            64'(bus.pending[bus.llu_issue_rd]), 0);
      if (preq)
        chk("hz_pipe", 64'(bus.pending[bus.rd_w]), 0);
    end
    acc = bus.llu_valid && e_rdy;
    if (rst) begin
      mq.delete();
      pend = '0;
      starve = 0;
      drain = 0;
    end else begin
      if (!drain && src == 1 && mq.size() > 0) starve++;
      if (src == 2) begin
        pend[mq[0].rd] = 0;
        void'(mq.pop_front());
        starve = 0;
      end
      if (src == 3) pend[bus.llu_rd] = 0;
      if (acc && bus.llu_rd != 0 && src != 3) begin
        e.rd = int'(bus.llu_rd);
        e.d = bus.llu_data;
        mq.push_back(e);
      end
      if (bus.llu_issue && bus.llu_issue_rd != 0)
        pend[bus.llu_issue_rd] = 1;
      if (drain) begin
        drain = 0;
        starve = 0;
      end else if (starve >= LIMIT) begin
        drain = 1;
      end
    end
    last_acc = acc;
    @(negedge clk);
  endtask

  task automatic drive_rand(int dens);
    bit preq;
    int rd;
    if (last_acc && inflight.size() > 0)
      void'(inflight.pop_front());
    if ($urandom_range(0, 599) == 0) begin
      rst = 1;
      inflight.delete();
      idle();
      return;
    end
    rst = 0;
    if (!drain) begin
      rd = int'($urandom_range(0, NR - 1));
      if (pend[rd]) rd = 0;
      setp($urandom_range(0, 99) < dens, rd, $urandom);
      bus.reg_write_w = bus.wb_valid_w &&
                        $urandom_range(0, 4) != 0;
    end
    if (!(bus.llu_valid && !last_acc)) begin
      if (inflight.size() > 0 && $urandom_range(0, 1) == 1)
        setl(1, inflight[0], $urandom);
      else
        setl(0, 0, 0);
    end
    preq = bus.wb_valid_w && bus.reg_write_w &&
           bus.rd_w != 0;
    seti(0, 0);
    if ($urandom_range(0, 9) < 3) begin
      rd = int'($urandom_range(0, NR - 1));
      if (rd == 0 || (!pend[rd] &&
          !(preq && rd == int'(bus.rd_w)))) begin
        seti(1, rd);
        inflight.push_back(rd);
      end
    end
  endtask

  initial begin
    int dens;
    rst = 1;
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_we", 64'(bus.rf_we3), 0);
    chk("rst_ready", 64'(bus.llu_ready), 0);
    chk("rst_stall", 64'(bus.wb_stall), 0);
    cycle();
    rst = 0;
    #1;
    chk("rst_pending", 64'(bus.pending), 0);
    cycle();

    seti(1, 5);
    cycle();
    seti(0, 0);
    setl(1, 5, 32'hDEADBEEF);
    #1;
    chk("byp_pend_set", 64'(bus.pending[5]), 1);
    chk("byp_we", 64'(bus.rf_we3), 1);
    chk("byp_a3", 64'(bus.rf_a3), 5);
    chk("byp_wd3", 64'(bus.rf_wd3), 64'hDEADBEEF);
    chk("byp_ready", 64'(bus.llu_ready), 1);
    cycle();
    idle();
    #1;
    chk("byp_pend_clr", 64'(bus.pending[5]), 0);
    cycle();

    seti(1, 7);
    cycle();
    seti(0, 0);
    setp(1, 3, 32'h11);
    setl(1, 7, 32'h22);
    #1;
    chk("col_a3", 64'(bus.rf_a3), 3);
    chk("col_wd3", 64'(bus.rf_wd3), 64'h11);
    cycle();
    idle();
    #1;
    chk("col2_we", 64'(bus.rf_we3), 1);
    chk("col2_a3", 64'(bus.rf_a3), 7);
    chk("col2_wd3", 64'(bus.rf_wd3), 64'h22);
    cycle();

    seti(1, 10); cycle();
    seti(1, 11); cycle();
    seti(1, 12); cycle();
    seti(0, 0);
    setp(1, 1, 32'hA1);
    setl(1, 10, 32'h1010);
    cycle();
    setp(1, 1, 32'hA2);
    setl(1, 11, 32'h1111);
    #1;
    chk("full_rdy2", 64'(bus.llu_ready), 1);
    cycle();
    setp(1, 1, 32'hA3);
    setl(1, 12, 32'h1212);
    #1;
    chk("full_rdy3", 64'(bus.llu_ready), 0);
    cycle();
    setp(0, 0, 0);
    #1;
    chk("full_deq_rdy", 64'(bus.llu_ready), 0);
    chk("full_deq_a3", 64'(bus.rf_a3), 10);
    cycle();
    #1;
    chk("full_rdy_back", 64'(bus.llu_ready), 1);
    chk("full_a3_11", 64'(bus.rf_a3), 11);
    cycle();
    setl(0, 0, 0);
    #1;
    chk("full_a3_12", 64'(bus.rf_a3), 12);
    cycle();

    seti(1, 13);
    cycle();
    seti(0, 0);
    setp(1, 2, 32'h200);
    setl(1, 13, 32'h1313);
    cycle();
    setl(0, 0, 0);
    for (int i = 1; i <= LIMIT; i++) begin
      setp(1, 2, 32'h200 + i);
      #1;
      chk("stv_nostall", 64'(bus.wb_stall), 0);
      cycle();
    end
    #1;
    chk("stv_stall", 64'(bus.wb_stall), 1);
    chk("stv_a3", 64'(bus.rf_a3), 13);
    chk("stv_wd3", 64'(bus.rf_wd3), 64'h1313);
    cycle();
    #1;
    chk("stv_release", 64'(bus.wb_stall), 0);
    chk("stv_held_a3", 64'(bus.rf_a3), 2);
    chk("stv_held_wd3", 64'(bus.rf_wd3), 64'h204);
    cycle();
    idle();
    cycle();

    setl(1, 0, 32'h55);
    #1;
    chk("x0_we", 64'(bus.rf_we3), 0);
    chk("x0_ready", 64'(bus.llu_ready), 1);
    cycle();
    idle();
    seti(1, 9);
    cycle();
    setl(1, 9, 32'h99);
    hz_en = 0;
    #1;
    chk("sw_a3", 64'(bus.rf_a3), 9);
    cycle();
    hz_en = 1;
    idle();
    #1;
    chk("sw_pend", 64'(bus.pending[9]), 1);
    cycle();
    setl(1, 9, 32'h999);
    cycle();
    idle();
    #1;
    chk("sw_pend_clr", 64'(bus.pending[9]), 0);
    cycle();

    seti(1, 7); cycle();
    seti(1, 10); cycle();
    seti(0, 0);
    setp(1, 1, 32'h77);
    setl(1, 7, 32'h70);
    cycle();
    setl(1, 10, 32'hA0);
    cycle();
    setl(0, 0, 0);
    rst = 1;
    #1;
    chk("mr_pend", 64'(bus.pending), 64'h480);
    chk("mr_we", 64'(bus.rf_we3), 0);
    chk("mr_ready", 64'(bus.llu_ready), 0);
    cycle();
    rst = 0;
    idle();
    #1;
    chk("mr_pend_clr", 64'(bus.pending), 0);
    chk("mr_we_after", 64'(bus.rf_we3), 0);
    cycle();
    seti(1, 5);
    cycle();
    seti(0, 0);
    setl(1, 5, 32'hCAFEF00D);
    #1;
    chk("mr_byp_we", 64'(bus.rf_we3), 1);
    chk("mr_byp_wd3", 64'(bus.rf_wd3), 64'hCAFEF00D);
    cycle();
    idle();
    cycle();

    last_acc = 0;
    dens = 50;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) dens = int'($urandom_range(20, 98));
      drive_rand(dens);
      cycle();
    end
    rst = 0;
    idle();
    repeat (4) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
